ws2811_frame_ctrl: RTL

WS2811_FRAME_CTRL -- requirements
Module: ws2811_frame_ctrl

---
 rtl/ws2811_frame_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/ws2811_frame_ctrl.sv
// WS2811 frame controller: walks the frame buffer one pixel at a time, optionally gamma
// corrects each channel, hands {G,R,B} words to the serializer, then holds the latch gap.
module ws2811_gamma (
   input  logic [7:0] din,
   output logic [7:0] dout
);
   // round(255 * (x/255)^2.8)
   localparam logic [7:0] LUT [256] = '{
      8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,
      8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd0,   8'd1,   8'd1,   8'd1,   8'd1,
      8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd1,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2,   8'd2,
      8'd2,   8'd3,   8'd3,   8'd3,   8'd3,   8'd3,   8'd3,   8'd3,   8'd4,   8'd4,   8'd4,   8'd4,   8'd4,   8'd5,   8'd5,   8'd5,
      8'd5,   8'd6,   8'd6,   8'd6,   8'd6,   8'd7,   8'd7,   8'd7,   8'd7,   8'd8,   8'd8,   8'd8,   8'd9,   8'd9,   8'd9,   8'd10,
      8'd10,  8'd10,  8'd11,  8'd11,  8'd11,  8'd12,  8'd12,  8'd13,  8'd13,  8'd13,  8'd14,  8'd14,  8'd15,  8'd15,  8'd16,  8'd16,
      8'd17,  8'd17,  8'd18,  8'd18,  8'd19,  8'd19,  8'd20,  8'd20,  8'd21,  8'd21,  8'd22,  8'd22,  8'd23,  8'd24,  8'd24,  8'd25,
      8'd25,  8'd26,  8'd27,  8'd27,  8'd28,  8'd29,  8'd29,  8'd30,  8'd31,  8'd32,  8'd32,  8'd33,  8'd34,  8'd35,  8'd35,  8'd36,
      8'd37,  8'd38,  8'd39,  8'd39,  8'd40,  8'd41,  8'd42,  8'd43,  8'd44,  8'd45,  8'd46,  8'd47,  8'd48,  8'd49,  8'd50,  8'd50,
      8'd51,  8'd52,  8'd54,  8'd55,  8'd56,  8'd57,  8'd58,  8'd59,  8'd60,  8'd61,  8'd62,  8'd63,  8'd64,  8'd66,  8'd67,  8'd68,
      8'd69,  8'd70,  8'd72,  8'd73,  8'd74,  8'd75,  8'd77,  8'd78,  8'd79,  8'd81,  8'd82,  8'd83,  8'd85,  8'd86,  8'd87,  8'd89,
      8'd90,  8'd92,  8'd93,  8'd95,  8'd96,  8'd98,  8'd99,  8'd101, 8'd102, 8'd104, 8'd105, 8'd107, 8'd109, 8'd110, 8'd112, 8'd114,
      8'd115, 8'd117, 8'd119, 8'd120, 8'd122, 8'd124, 8'd126, 8'd127, 8'd129, 8'd131, 8'd133, 8'd135, 8'd137, 8'd138, 8'd140, 8'd142,
      8'd144, 8'd146, 8'd148, 8'd150, 8'd152, 8'd154, 8'd156, 8'd158, 8'd160, 8'd162, 8'd164, 8'd167, 8'd169, 8'd171, 8'd173, 8'd175,
      8'd177, 8'd180, 8'd182, 8'd184, 8'd186, 8'd189, 8'd191, 8'd193, 8'd196, 8'd198, 8'd200, 8'd203, 8'd205, 8'd208, 8'd210, 8'd213,
      8'd215, 8'd218, 8'd220, 8'd223, 8'd225, 8'd228, 8'd231, 8'd233, 8'd236, 8'd239, 8'd241, 8'd244, 8'd247, 8'd249, 8'd252, 8'd255
   };

   assign dout = LUT[din];
endmodule

module ws2811_frame_ctrl #(
   parameter int NUM_PIXELS   = 256,
   parameter int ADDR_W       = 8,
   parameter int LATCH_CYCLES = 2500
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              gamma_en,
   output logic              busy,
   output logic              done,
   output logic              fb_rd,
   output logic [ADDR_W-1:0] fb_addr,
   input  logic [23:0]       fb_data,
   output logic [23:0]       px_data,
   output logic              px_valid,
   input  logic              px_ready,
   input  logic              ser_idle,
   output logic [2:0]        state_dbg
);
   // px_valid/px_ready: a word transfers on any clock where both are 1; once raised,
   // px_valid and px_data stay put until that transfer happens.
   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_WAIT    = 3'd2,
      S_PRESENT = 3'd3,
      S_LATCH   = 3'd4,
      S_DONE    = 3'd5
   } state_t;

   localparam int CNT_W = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
   localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(LATCH_CYCLES - 1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS - 1);

   state_t           state, state_n;
   logic [CNT_W-1:0] lcnt;
   logic             gamma_en_r;
   logic             hs, last;
   logic [7:0]       g_r, g_g, g_b;
   logic [7:0]       c_r, c_g, c_b;

   ws2811_gamma u_gamma_r (.din(fb_data[23:16]), .dout(g_r));
   ws2811_gamma u_gamma_g (.din(fb_data[15:8]),  .dout(g_g));
   ws2811_gamma u_gamma_b (.din(fb_data[7:0]),   .dout(g_b));

   assign c_r       = gamma_en_r ? g_r : fb_data[23:16];
   assign c_g       = gamma_en_r ? g_g : fb_data[15:8];
   assign c_b       = gamma_en_r ? g_b : fb_data[7:0];
   assign hs        = (state == S_PRESENT) && px_valid && px_ready;
   assign last      = (fb_addr == LAST_ADDR);
   assign state_dbg = state;

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:    if (start) state_n = S_FETCH;
         S_FETCH:   state_n = S_WAIT;
         S_WAIT:    state_n = S_PRESENT;
         S_PRESENT: if (hs) state_n = last ? S_LATCH : S_FETCH;
         S_LATCH:   if (ser_idle && (lcnt == LAST_CNT)) state_n = S_DONE;
         S_DONE:    state_n = S_IDLE;
         default:   state_n = S_IDLE;
      endcase
   end

   // Strobes are registered from the next state so they line up with the state they belong to.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         fb_rd      <= 1'b0;
         px_valid   <= 1'b0;
         fb_addr    <= '0;
         px_data    <= '0;
         gamma_en_r <= 1'b0;
         lcnt       <= '0;
      end else begin
         state    <= state_n;
         busy     <= (state_n != S_IDLE);
         done     <= (state_n == S_DONE);
         fb_rd    <= (state_n == S_FETCH);
         px_valid <= (state_n == S_PRESENT);

         if ((state == S_IDLE) && start) begin
            gamma_en_r <= gamma_en;
            fb_addr    <= '0;
         end
         if (hs && !last) fb_addr <= fb_addr + ADDR_W'(1);
         if (state == S_WAIT) px_data <= {c_g, c_r, c_b};

         // Only an unbroken run of idle cycles counts toward the latch gap.
         if ((state == S_LATCH) && ser_idle && (lcnt != LAST_CNT)) lcnt <= lcnt + CNT_W'(1);
         else lcnt <= '0;
      end
   end
endmodule
